// File: rtl/uart_fifo_ext.sv
// Circular-buffer FIFO for the UART16550 TX/RX paths: first-word-fall-through head,
// live fill level, synchronous flush, per-entry error tags and overrun/underrun pulses.
module uart_fifo_ext #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              din_err,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              dout_err,
   input  logic [AW:0]       threshold,
   output logic [AW:0]       level,
   output logic              empty,
   output logic              full,
   output logic              thr_trigger,
   output logic              err_in_fifo,
   output logic              overrun,
   output logic              underrun
);

   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

   // Each entry carries its error tag in the top bit.
   logic [DATA_W:0] mem [DEPTH];

   logic [AW-1:0]   wptr_reg, wptr_next;
   logic [AW-1:0]   rptr_reg, rptr_next;
   logic [AW:0]     level_reg, level_next;
   logic [AW:0]     err_cnt_reg, err_cnt_next;
   logic            thr_reg, thr_next;
   logic            overrun_reg, overrun_next;
   logic            underrun_reg, underrun_next;
   logic            active;
   logic            push_ok, pop_ok;
   logic [DATA_W:0] head;

   assign head  = mem[rptr_reg];
   assign empty = (level_reg == '0);
   assign full  = (level_reg == DEPTH_LVL);

   always_comb begin
      active        = en & ~flush;
      pop_ok        = active & pop & ~empty;
      push_ok       = active & push & (~full | pop_ok);
      overrun_next  = active & push & ~push_ok;
      underrun_next = active & pop & ~pop_ok;
      wptr_next     = wptr_reg;
      rptr_next     = rptr_reg;
      level_next    = level_reg;
      err_cnt_next  = err_cnt_reg;

      if (!active) begin
         wptr_next    = '0;
         rptr_next    = '0;
         level_next   = '0;
         err_cnt_next = '0;
      end else begin
         if (push_ok)
            wptr_next = wptr_reg + 1'b1;
         if (pop_ok)
            rptr_next = rptr_reg + 1'b1;

         case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
         endcase

         // A tagged entry arriving and another leaving in the same cycle cancel out.
         case ({push_ok & din_err, pop_ok & head[DATA_W]})
            2'b10:   err_cnt_next = err_cnt_reg + 1'b1;
            2'b01:   err_cnt_next = err_cnt_reg - 1'b1;
            default: err_cnt_next = err_cnt_reg;
         endcase
      end

      // Built from the next level so the flag lines up with the level output.
      thr_next = (threshold != '0) && (level_next >= threshold);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         level_reg    <= '0;
         err_cnt_reg  <= '0;
         thr_reg      <= 1'b0;
         overrun_reg  <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         wptr_reg     <= wptr_next;
         rptr_reg     <= rptr_next;
         level_reg    <= level_next;
         err_cnt_reg  <= err_cnt_next;
         thr_reg      <= thr_next;
         overrun_reg  <= overrun_next;
         underrun_reg <= underrun_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr_reg] <= {din_err, din};
   end

   assign dout        = empty ? '0 : head[DATA_W-1:0];
   assign dout_err    = ~empty & head[DATA_W];
   assign level       = level_reg;
   assign thr_trigger = thr_reg;
   assign err_in_fifo = (err_cnt_reg != '0);
   assign overrun     = overrun_reg;
   assign underrun    = underrun_reg;

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Self-checking bench for uart_fifo_ext: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO.
module tb_uart_fifo_ext;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, flush, push, pop, din_err;
   logic [7:0] din;
   logic [4:0] threshold;
   logic [7:0] dout;
   logic       dout_err;
   logic [4:0] level;
   logic       empty, full, thr_trigger, err_in_fifo, overrun, underrun;

   int total = 0;
   int bad   = 0;

   logic [8:0] q[$];
   logic       exp_ovr, exp_und, exp_thr;

   uart_fifo_ext #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .push(push), .din(din),
      .din_err(din_err), .pop(pop), .dout(dout), .dout_err(dout_err),
      .threshold(threshold), .level(level), .empty(empty), .full(full),
      .thr_trigger(thr_trigger), .err_in_fifo(err_in_fifo),
      .overrun(overrun), .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_dout();
      return (q.size() == 0) ? 8'h00 : q[0][7:0];
   endfunction

   function automatic logic model_dout_err();
      return (q.size() == 0) ? 1'b0 : q[0][8];
   endfunction

   function automatic logic model_err();
      foreach (q[i]) if (q[i][8]) return 1'b1;
      return 1'b0;
   endfunction

   // Advance the model by the rules for one edge, then cross that edge.
   task automatic tick();
      logic pop_acc, push_acc;
      exp_ovr = 1'b0;
      exp_und = 1'b0;
      if (!en || flush) begin
         q.delete();
      end else begin
         pop_acc  = pop && (q.size() != 0);
         push_acc = push && ((q.size() < DEPTH) || pop_acc);
         exp_und  = pop && !pop_acc;
         exp_ovr  = push && !push_acc;
         if (pop_acc) void'(q.pop_front());
         if (push_acc) q.push_back({din_err, din});
      end
      exp_thr = (threshold != 0) && (q.size() >= int'(threshold));
      @(posedge clk);
      #1;
      $display("txn t=%0t en=%0b fl=%0b push=%0b din=%02h err=%0b pop=%0b -> lvl=%0d dout=%02h",
               $time, en, flush, push, din, din_err, pop, level, dout);
   endtask

   task automatic idle();
      en = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; din_err = 1'b0; din = 8'h00;
   endtask

   task automatic clear();
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if ({level, empty, full, thr_trigger, err_in_fifo, overrun, underrun} !== {5'd0, 6'b100000}) begin
         bad++;
         $display("FAIL reset_flags got lvl=%0d e=%0b f=%0b t=%0b err=%0b o=%0b u=%0b want lvl=0 e=1 others 0",
                  level, empty, full, thr_trigger, err_in_fifo, overrun, underrun);
      end
      total++;
      if ({dout, dout_err} !== 9'h000) begin
         bad++;
         $display("FAIL reset_dout got %02h/%0b want 00/0", dout, dout_err);
      end
   endtask

   task automatic test_basic();
      idle();
      push = 1'b1;
      din = 8'h11; tick();
      total++;
      if (dout !== 8'h11) begin bad++; $display("FAIL fwft_latency got %02h want 11", dout); end
      din = 8'h22; tick();
      din = 8'h33; tick();
      push = 1'b0;
      total++;
      if (level !== 5'd3 || dout !== 8'h11) begin
         bad++; $display("FAIL basic_fill got lvl=%0d dout=%02h want lvl=3 dout=11", level, dout);
      end
      pop = 1'b1;
      tick();
      total++;
      if (dout !== 8'h22) begin bad++; $display("FAIL basic_pop1 got %02h want 22", dout); end
      tick();
      total++;
      if (dout !== 8'h33) begin bad++; $display("FAIL basic_pop2 got %02h want 33", dout); end
      tick();
      total++;
      if (empty !== 1'b1 || dout !== 8'h00 || level !== 5'd0) begin
         bad++; $display("FAIL basic_pop3 got e=%0b dout=%02h lvl=%0d want e=1 dout=00 lvl=0", empty, dout, level);
      end
      idle();
   endtask

   task automatic test_full();
      logic [7:0] first_d, second_d;
      idle();
      push = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         din = 8'($urandom);
         if (i == 0) first_d = din;
         if (i == 1) second_d = din;
         tick();
      end
      din = 8'hAA;
      tick();
      total++;
      if ({full, overrun, level} !== {2'b11, 5'd16} || dout !== first_d) begin
         bad++; $display("FAIL full_overrun got f=%0b o=%0b lvl=%0d dout=%02h want f=1 o=1 lvl=16 dout=%02h",
                         full, overrun, level, dout, first_d);
      end
      push = 1'b0;
      tick();
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pulse got %0b want 0", overrun); end
      push = 1'b1; pop = 1'b1; din = 8'h55;
      tick();
      total++;
      if (level !== 5'd16 || overrun !== 1'b0 || underrun !== 1'b0 || dout !== second_d) begin
         bad++; $display("FAIL full_pushpop got lvl=%0d o=%0b u=%0b dout=%02h want lvl=16 o=0 u=0 dout=%02h",
                         level, overrun, underrun, dout, second_d);
      end
      push = 1'b0;
      while (q.size() != 0) begin
         total++;
         if (dout !== model_dout()) begin
            bad++; $display("FAIL full_drain got %02h want %02h", dout, model_dout());
         end
         if (q.size() == 1) begin
            total++;
            if (dout !== 8'h55) begin bad++; $display("FAIL full_last got %02h want 55", dout); end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_wrap();
      logic [7:0] wr_val = 8'h00;
      logic [7:0] rd_val = 8'h00;
      idle();
      for (int r = 0; r < 8; r++) begin
         push = 1'b1;
         for (int k = 0; k < 5; k++) begin
            din = wr_val; wr_val++;
            tick();
         end
         push = 1'b0; pop = 1'b1;
         for (int k = 0; k < 5; k++) begin
            total++;
            if (dout !== rd_val) begin bad++; $display("FAIL wrap_data got %02h want %02h", dout, rd_val); end
            rd_val++;
            tick();
         end
         pop = 1'b0;
      end
      pop = 1'b1;
      tick();
      total++;
      if (underrun !== 1'b1 || level !== 5'd0) begin
         bad++; $display("FAIL underrun got u=%0b lvl=%0d want u=1 lvl=0", underrun, level);
      end
      pop = 1'b0;
      tick();
      total++;
      if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_pulse got %0b want 0", underrun); end
      idle();
   endtask

   task automatic test_threshold();
      idle();
      threshold = 5'd4;
      push = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 8'($urandom);
         tick();
         total++;
         if (thr_trigger !== (i == 3) || level !== 5'(i + 1)) begin
            bad++; $display("FAIL thr_rise got t=%0b lvl=%0d want t=%0b lvl=%0d", thr_trigger, level, (i == 3), i + 1);
         end
      end
      push = 1'b0; pop = 1'b1;
      tick();
      total++;
      if (thr_trigger !== 1'b0) begin bad++; $display("FAIL thr_fall got %0b want 0", thr_trigger); end
      pop = 1'b0; push = 1'b1; threshold = 5'd0;
      for (int i = 0; i < 8; i++) begin
         din = 8'($urandom);
         tick();
         total++;
         if (thr_trigger !== 1'b0) begin bad++; $display("FAIL thr_zero got %0b want 0 lvl=%0d", thr_trigger, level); end
      end
      clear();
   endtask

   task automatic test_err();
      idle();
      push = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'(8'h40 + i); din_err = (i == 1);
         tick();
      end
      push = 1'b0; din_err = 1'b0;
      total++;
      if (err_in_fifo !== 1'b1) begin bad++; $display("FAIL err_set got %0b want 1", err_in_fifo); end
      pop = 1'b1;
      tick();
      total++;
      if (err_in_fifo !== 1'b1 || dout_err !== 1'b1) begin
         bad++; $display("FAIL err_pop1 got err=%0b derr=%0b want 1/1", err_in_fifo, dout_err);
      end
      tick();
      total++;
      if (err_in_fifo !== 1'b0 || dout_err !== 1'b0) begin
         bad++; $display("FAIL err_pop2 got err=%0b derr=%0b want 0/0", err_in_fifo, dout_err);
      end
      clear();
   endtask

   task automatic test_flush();
      for (int mode = 0; mode < 2; mode++) begin
         idle();
         push = 1'b1;
         for (int i = 0; i < 5; i++) begin
            din = 8'($urandom); din_err = (i == 2);
            tick();
         end
         din_err = 1'b1;
         pop = (mode == 1);
         if (mode == 0) flush = 1'b1;
         else en = 1'b0;
         tick();
         total++;
         if ({level, empty, err_in_fifo, overrun, underrun} !== {5'd0, 4'b1000}) begin
            bad++; $display("FAIL flush_mode%0d got lvl=%0d e=%0b err=%0b o=%0b u=%0b want lvl=0 e=1 0 0 0",
                            mode, level, empty, err_in_fifo, overrun, underrun);
         end
      end
      idle();
   endtask

   task automatic test_rst_mid();
      idle();
      threshold = 5'd2;
      push = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'(8'hC0 + i); din_err = 1'b1;
         tick();
      end
      #3;
      rst = 1'b1;
      q.delete();
      #1;
      total++;
      if ({level, empty, full, thr_trigger, err_in_fifo, overrun, underrun, dout, dout_err} !==
          {5'd0, 6'b100000, 9'h000}) begin
         bad++; $display("FAIL rst_async got lvl=%0d e=%0b f=%0b t=%0b err=%0b dout=%02h derr=%0b want reset values",
                         level, empty, full, thr_trigger, err_in_fifo, dout, dout_err);
      end
      @(negedge clk);
      rst = 1'b0;
      threshold = 5'd0;
      din = 8'h5A; din_err = 1'b0;
      tick();
      push = 1'b0;
      total++;
      if (level !== 5'd1 || dout !== 8'h5A) begin
         bad++; $display("FAIL rst_restart got lvl=%0d dout=%02h want lvl=1 dout=5a", level, dout);
      end
      clear();
   endtask

   task automatic test_random();
      idle();
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) threshold = 5'($urandom_range(0, 18));
         push    = (i % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         pop     = (i % 100 < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         din     = 8'($urandom);
         din_err = ($urandom_range(0, 3) == 0);
         flush   = ($urandom_range(0, 40) == 0);
         en      = ($urandom_range(0, 40) != 0);
         tick();
         total++;
         if (level !== 5'(q.size())) begin
            bad++; $display("FAIL rnd_level i=%0d got %0d want %0d", i, level, q.size());
         end
         total++;
         if (dout !== model_dout() || dout_err !== model_dout_err()) begin
            bad++; $display("FAIL rnd_head i=%0d got %02h/%0b want %02h/%0b", i, dout, dout_err, model_dout(), model_dout_err());
         end
         total++;
         if ({empty, full, thr_trigger, err_in_fifo, overrun, underrun} !==
             {q.size() == 0, q.size() == DEPTH, exp_thr, model_err(), exp_ovr, exp_und}) begin
            bad++; $display("FAIL rnd_flags i=%0d got e=%0b f=%0b t=%0b err=%0b o=%0b u=%0b want %0b %0b %0b %0b %0b %0b",
                            i, empty, full, thr_trigger, err_in_fifo, overrun, underrun,
                            q.size() == 0, q.size() == DEPTH, exp_thr, model_err(), exp_ovr, exp_und);
         end
      end
      threshold = 5'd0;
      clear();
   endtask

   initial begin
      rst = 1'b1;
      threshold = 5'd0;
      idle();
      #12;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_threshold();
      test_err();
      test_flush();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_fifo_ext.md
Name: uart_fifo_ext

Overview:
Parametrised circular-buffer FIFO for the UART16550 TX/RX paths. It is the successor to the single-width shift-register FIFO and adds:
- configurable data width and depth;
- pointer-based storage with no data shifting;
- a live fill-level output;
- synchronous flush;
- a per-entry error tag with an "error anywhere in FIFO" flag, used for LSR bit 7.

Reads are first-word-fall-through. The head entry is visible on dout whenever empty=0.

Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 16, number of entries; power of two, >= 2.
- AW (localparam), $clog2(DEPTH), pointer width. Level and threshold are AW+1 bits wide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  FIFO enable. When 0, the FIFO is held flushed and push/pop are ignored.
- flush  in  1  synchronous clear of contents (FCR reset bits).
- push  in  1  write request.
- din  in  DATA_W  write data.
- din_err  in  1  error tag stored with din (parity/framing/break). Tie to 0 for TX.
- pop  in  1  read request; consumes the head entry.
- dout  out  DATA_W  head data. Value is 0 when empty.
- dout_err  out  1  head error tag. Value is 0 when empty.
- threshold  in  AW+1  trigger level; 0 disables the trigger.
- level  out  AW+1  current number of stored entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- thr_trigger  out  1  registered flag: level>=threshold and threshold!=0.
- err_in_fifo  out  1  at least one stored entry has its error tag set.
- overrun  out  1  one-cycle pulse: push was rejected.
- underrun  out  1  one-cycle pulse: pop was rejected.

Behaviour:
- Reset (rst=1, async):
  - rptr, wptr and level go to 0; error count goes to 0.
  - empty=1, full=0, thr_trigger=0, err_in_fifo=0, overrun=0, underrun=0.
  - dout=0, dout_err=0.
  - Memory contents are don't-care.
- Storage: mem[DEPTH] of {din_err, din}.
  - wptr and rptr are AW bits and wrap modulo DEPTH naturally.
  - level is tracked in a separate register, which disambiguates full from empty.
- Acceptance, evaluated at the rising clk edge with en=1 and flush=0:
  - push_ok = push & (~full | pop_ok).
  - pop_ok = pop & ~empty.
  - When full, a simultaneous push+pop accepts both; level is unchanged.
  - When empty, a simultaneous push+pop accepts only the push; underrun pulses and level becomes 1.
- Pointer and level updates:
  - push_ok writes mem[wptr] and increments wptr.
  - pop_ok increments rptr.
  - level changes by +1 (push_ok only), -1 (pop_ok only), or 0 (both or neither).
- Latency:
  - Data pushed into an empty FIFO appears on dout in the cycle after the push edge.
  - After a pop, dout shows the next entry in the cycle after the pop edge.
- Error count (AW+1 bits):
  - +1 when push_ok with din_err=1.
  - -1 when pop_ok removes an entry whose tag is set.
  - Both events in the same cycle cancel.
  - err_in_fifo = (error count != 0), derived combinationally from the register.
- Flush priority: rst > (flush | ~en) > push/pop.
  - flush, or en=0, clears the pointers, level and error count at the next edge.
  - push/pop requests in that cycle are discarded.
  - overrun and underrun are not asserted in that cycle.
- Overrun and underrun pulses:
  - overrun is registered; it is 1 for exactly one cycle following an edge where push=1 and push_ok=0 (en=1, flush=0).
  - underrun is the same, for pop=1 with pop_ok=0.
  - Neither flag is sticky; the LSR logic latches them.
- thr_trigger:
  - Registered from the next-state level: thr_trigger <= (level_next >= threshold) & (threshold != 0).
  - It is therefore aligned with level.
  - A threshold change takes effect at the next edge.
  - Threshold values greater than DEPTH never trigger.
- Rejected requests: a rejected push or pop never corrupts memory, the pointers or level.
- Reset mid-operation: all state is cleared immediately and asynchronously; the next edge after release behaves as for an empty FIFO.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles:
  - Expect level=3 and dout=0x11.
  - Pop 3 times: dout reads 0x22, 0x33, then empty=1 and dout=0.
- Fill to DEPTH=16, then push 0xAA:
  - Expect full=1, a single overrun pulse, level=16, and the head unchanged.
  - Then push+pop in the same cycle: level stays 16 and the last entry equals the new din.
- Wrap-around: 40 push/pop pairs with level oscillating between 0 and 5, using an incrementing data pattern:
  - The output sequence must match the input exactly.
  - Pop when empty: a single underrun pulse and no level change.
- Set threshold=4 and push 4 words:
  - thr_trigger rises in the same cycle that level becomes 4.
  - One pop drops it.
  - With threshold=0, thr_trigger never asserts.
- Push 3 words with din_err = 0, 1, 0:
  - Expect err_in_fifo=1.
  - Pop 1: still 1, and dout_err=1.
  - Pop 2: err_in_fifo=0.
- With 5 entries stored, assert flush together with push=1:
  - Next cycle: level=0, empty=1, err_in_fifo=0, no overrun.
  - The same holds for en=0.
  - Assert rst mid-burst: outputs go to their reset values asynchronously.
